condlogic_pipe: RTL and testbench
=================================

Name: condlogic_pipe

Overview:
- Pipelined, multi-context conditional-execution unit for the ARM core's Execute stage.
- Keeps NUM_CTX banked NZCV flag registers and evaluates the 4-bit condition field against the addressed bank.
- Gates branch, register-write and memory-write controls; registers the write controls into the Memory stage.
- Supports stall (en) and flush, and keeps saturating executed/squashed instruction counters for performance monitoring.

Parameters:
- NUM_CTX, 2, number of independent flag banks (processor modes/threads); must be >= 1.
- CTX_W, $clog2(NUM_CTX) (min 1), width of the context select.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  pipeline enable; 0 = stall.
- flush  in  1  kill the instruction currently in E.
- valid_e  in  1  E-stage instruction valid.
- ctx_e  in  CTX_W  flag bank used by the E instruction.
- cond_e  in  4  ARM condition field.
- alu_flags_e  in  4  ALU result flags {N,Z,C,V}.
- flag_w_e  in  2  flag write request: [1]=NZ, [0]=CV.
- pcs_e  in  1  instruction writes PC.
- reg_w_e  in  1  instruction writes a register.
- mem_w_e  in  1  instruction writes memory.
- cnt_clr  in  1  synchronous clear of both counters.
- cond_ex_e  out  1  condition passed (combinational).
- pc_src_e  out  1  take PC redirect (combinational).
- reg_write_m  out  1  registered, gated register write.
- mem_write_m  out  1  registered, gated memory write.
- flags_e  out  4  current flags of bank ctx_e.
- exec_count  out  CNT_W  number of executed instructions.
- squash_count  out  CNT_W  number of condition-failed instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - All flag banks = 4'b0000.
  - reg_write_m = mem_write_m = 0.
  - exec_count = squash_count = 0.
  - Combinational outputs follow their inputs against the reset state.
- Define live = valid_e & en & ~flush.
- Condition evaluation, against flags_e = bank[ctx_e]:
  - Standard ARM codes 0000–1101 (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE); GE means N==V.
  - 1110 = always.
  - 1111 = never: cond_ex_e=0 and the instruction counts as squashed.
  - cond_ex_e is the raw evaluation, not gated by live.
- pc_src_e = live & pcs_e & cond_ex_e. Same-cycle, zero latency.
- Flag update on the clock edge when live & cond_ex_e:
  - flag_w_e[1] writes bank[ctx_e][3:2] from alu_flags_e[3:2].
  - flag_w_e[0] writes bank[ctx_e][1:0] from alu_flags_e[1:0].
  - Other banks are never touched.
  - New flags become visible to the next E instruction through the register; no intra-cycle bypass.
- M register update:
  - flush=1: cleared to 0 regardless of en (flush has priority over stall).
  - flush=0, en=1: reg_write_m <= valid_e & reg_w_e & cond_ex_e; mem_write_m <= valid_e & mem_w_e & cond_ex_e.
  - flush=0, en=0: hold.
  - Latency from E decision to M outputs is 1 cycle.
- Counters:
  - cnt_clr=1: both counters <= 0. Clear wins over any increment in the same cycle.
  - Otherwise, if live: cond_ex_e=1 increments exec_count, else squash_count increments.
  - Both counters saturate at all-ones with no wrap.
- Stall: no flag writes, no counting, pc_src_e=0, M registers hold.
- Reset asserted mid-stall or mid-flush: asynchronous reset overrides everything immediately.
- ctx_e >= NUM_CTX (non-power-of-two NUM_CTX): reads return 0000, writes are discarded, and evaluation proceeds on 0000.

Decomposition:
- Shared package arm_cond_pkg:
  - cond_t enum (EQ..AL, NV).
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flag_w bit indices FW_NZ=1, FW_CV=0.
- Sub-module: the existing combinational condcheck (Cond, Flags → CondEx), extended so that NV returns 0. It is instantiated once.
- The bank array, M register and counters live in condlogic_pipe.

Test Plan:
- Reset, then SUBS in ctx 0 (valid, flag_w=11, alu_flags=0100), then BEQ (cond=0000, pcs=1) → flags_e=0100 next cycle; pc_src_e=1; exec_count=2.
- Bank isolation: write NZCV=1000 in ctx 1, then a ctx 0 instruction with cond=MI (0100) → cond_ex_e=0; reg_write_m=0 next cycle; squash_count=1; bank 1 still reads 1000.
- Partial write: bank=0110, then flag_w=10 with alu_flags=1001 → bank=1010 (C kept, V kept); GT (1100) → cond_ex_e=0.
- Stall then flush: en=0 with a valid STR (mem_w=1, cond=AL) → mem_write_m holds its old value, no count. Next, flush=1 with en=0 → mem_write_m=0 after the edge, flags unchanged.
- Saturation and clear: CNT_W=4, 17 live AL instructions → exec_count=15. cnt_clr together with a live instruction → exec_count=0.
- Async reset mid-stream: drop reset between clock edges with reg_write_m=1 → outputs go to 0 before the next edge; cond=1111 after reset → cond_ex_e=0 and squash_count increments.

Source files
------------

// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code definitions: condition enum, NZCV bit positions
// and flag-write request bit positions.
package arm_cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage : arm_cond_pkg

// File: rtl/condcheck.sv
// Combinational ARM condition evaluation.
// Ports: cond    - 4-bit condition field
//        flags   - current {N,Z,C,V}
//        cond_ex - 1 when the condition passes (NV never passes)
module condcheck
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Condition decode against the addressed flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b0;
        endcase
    end

endmodule : condcheck

// File: rtl/condlogic_pipe.sv
// Pipelined multi-context conditional-execution unit (Execute stage).
// Holds NUM_CTX banked NZCV registers, evaluates the condition of the E
// instruction, gates PC/register/memory writes, registers the write controls
// into M, and keeps saturating executed/squashed counters.
// Ports: clk, reset (async active-low), en (0 = stall), flush, valid_e, ctx_e,
//        cond_e, alu_flags_e, flag_w_e, pcs_e, reg_w_e, mem_w_e, cnt_clr;
//        cond_ex_e/pc_src_e/flags_e (combinational), reg_write_m/mem_write_m,
//        exec_count, squash_count (registered).
module condlogic_pipe
    import arm_cond_pkg::*;
#(
    parameter int unsigned NUM_CTX = 2,
    parameter int unsigned CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_e,
    input  logic [CTX_W-1:0] ctx_e,
    input  logic [3:0]       cond_e,
    input  logic [3:0]       alu_flags_e,
    input  logic [1:0]       flag_w_e,
    input  logic             pcs_e,
    input  logic             reg_w_e,
    input  logic             mem_w_e,
    input  logic             cnt_clr,
    output logic             cond_ex_e,
    output logic             pc_src_e,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [3:0]       flags_e,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] squash_count
);

    logic [NUM_CTX-1:0][3:0] bank_q, bank_d;
    logic                    reg_write_q, reg_write_d;
    logic                    mem_write_q, mem_write_d;
    logic [CNT_W-1:0]        exec_q, exec_d;
    logic [CNT_W-1:0]        squash_q, squash_d;
    logic [3:0]              flags_rd;
    logic                    live;

    // Bank read; an unmapped context reads as 0000
    always_comb begin
        flags_rd = 4'b0000;
        for (int i = 0; i < int'(NUM_CTX); i++) begin
            if (ctx_e == CTX_W'(i)) begin
                flags_rd = bank_q[i];
            end
        end
    end

    condcheck u_condcheck (
        .cond    (cond_e),
        .flags   (flags_rd),
        .cond_ex (cond_ex_e)
    );

    assign live     = valid_e & en & ~flush;
    assign pc_src_e = live & pcs_e & cond_ex_e;
    assign flags_e  = flags_rd;

    // Next-state: flag banks, M stage controls, counters
    always_comb begin
        bank_d      = bank_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        exec_d      = exec_q;
        squash_d    = squash_q;

        // Only the addressed bank is written; unmapped contexts match nothing
        if (live && cond_ex_e) begin
            for (int i = 0; i < int'(NUM_CTX); i++) begin
                if (ctx_e == CTX_W'(i)) begin
                    if (flag_w_e[FW_NZ]) begin
                        bank_d[i][FLAG_N] = alu_flags_e[FLAG_N];
                        bank_d[i][FLAG_Z] = alu_flags_e[FLAG_Z];
                    end
                    if (flag_w_e[FW_CV]) begin
                        bank_d[i][FLAG_C] = alu_flags_e[FLAG_C];
                        bank_d[i][FLAG_V] = alu_flags_e[FLAG_V];
                    end
                end
            end
        end

        // Flush beats stall
        if (flush) begin
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
        end else if (en) begin
            reg_write_d = valid_e & reg_w_e & cond_ex_e;
            mem_write_d = valid_e & mem_w_e & cond_ex_e;
        end

        // Clear beats increment; both counters saturate
        if (cnt_clr) begin
            exec_d   = '0;
            squash_d = '0;
        end else if (live) begin
            if (cond_ex_e) begin
                if (exec_q != '1) begin
                    exec_d = exec_q + CNT_W'(1);
                end
            end else begin
                if (squash_q != '1) begin
                    squash_d = squash_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q      <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            exec_q      <= '0;
            squash_q    <= '0;
        end else begin
            bank_q      <= bank_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            exec_q      <= exec_d;
            squash_q    <= squash_d;
        end
    end

    assign reg_write_m  = reg_write_q;
    assign mem_write_m  = mem_write_q;
    assign exec_count   = exec_q;
    assign squash_count = squash_q;

endmodule : condlogic_pipe

// File: tb/tb_condlogic_pipe.sv
// Directed bench for condlogic_pipe with a reference model and a queue of
// expected M-stage controls.
module tb_condlogic_pipe;

    localparam int unsigned NUM_CTX = 2;
    localparam int unsigned CTX_W   = 1;
    localparam int unsigned CNT_W   = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             flush;
    logic             valid_e;
    logic [CTX_W-1:0] ctx_e;
    logic [3:0]       cond_e;
    logic [3:0]       alu_flags_e;
    logic [1:0]       flag_w_e;
    logic             pcs_e;
    logic             reg_w_e;
    logic             mem_w_e;
    logic             cnt_clr;
    logic             cond_ex_e;
    logic             pc_src_e;
    logic             reg_write_m;
    logic             mem_write_m;
    logic [3:0]       flags_e;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] squash_count;

    condlogic_pipe #(
        .NUM_CTX (NUM_CTX),
        .CTX_W   (CTX_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .flush        (flush),
        .valid_e      (valid_e),
        .ctx_e        (ctx_e),
        .cond_e       (cond_e),
        .alu_flags_e  (alu_flags_e),
        .flag_w_e     (flag_w_e),
        .pcs_e        (pcs_e),
        .reg_w_e      (reg_w_e),
        .mem_w_e      (mem_w_e),
        .cnt_clr      (cnt_clr),
        .cond_ex_e    (cond_ex_e),
        .pc_src_e     (pc_src_e),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .flags_e      (flags_e),
        .exec_count   (exec_count),
        .squash_count (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rw;
        logic mw;
    } mexp_t;

    mexp_t      m_q[$];
    logic [3:0] mflags [NUM_CTX];
    int         mexec;
    int         msquash;
    logic       mrw;
    logic       mmw;
    int         total;
    int         bad;

    // Reference condition evaluation: pairs of codes share a base test,
    // the low bit inverts it
    function automatic logic cond_pass(input logic [3:0] cd, input logic [3:0] f);
        logic base;
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cd == 4'b1110) return 1'b1;
        if (cd == 4'b1111) return 1'b0;
        case (cd[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return cd[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_CTX); i++) mflags[i] = 4'b0000;
        mexec   = 0;
        msquash = 0;
        mrw     = 1'b0;
        mmw     = 1'b0;
        m_q.delete();
    endtask

    // One E-stage cycle: drive at negedge, check combinational outputs,
    // then check registered outputs just after the posedge
    task automatic step(input string tag, input logic v, input logic [CTX_W-1:0] c,
                        input logic [3:0] cd, input logic [3:0] al, input logic [1:0] fw,
                        input logic p, input logic r, input logic m,
                        input logic e, input logic f, input logic clr);
        logic [3:0] fcur;
        logic       ce;
        logic       lv;
        mexp_t      me;
        valid_e = v; ctx_e = c; cond_e = cd; alu_flags_e = al; flag_w_e = fw;
        pcs_e = p; reg_w_e = r; mem_w_e = m; en = e; flush = f; cnt_clr = clr;
        #1;
        fcur = (int'(c) < int'(NUM_CTX)) ? mflags[c] : 4'b0000;
        ce   = cond_pass(cd, fcur);
        lv   = v && e && !f;
        chk({tag, ".flags_e"}, 32'(flags_e), 32'(fcur));
        chk({tag, ".cond_ex_e"}, 32'(cond_ex_e), 32'(ce));
        chk({tag, ".pc_src_e"}, 32'(pc_src_e), 32'(lv && p && ce));
        if (lv && ce) begin
            if (fw[1]) mflags[c][3:2] = al[3:2];
            if (fw[0]) mflags[c][1:0] = al[1:0];
        end
        if (clr) begin
            mexec   = 0;
            msquash = 0;
        end else if (lv) begin
            if (ce) mexec   = (mexec   < 15) ? mexec + 1   : 15;
            else    msquash = (msquash < 15) ? msquash + 1 : 15;
        end
        if (f) begin
            mrw = 1'b0; mmw = 1'b0;
        end else if (e) begin
            mrw = v && r && ce; mmw = v && m && ce;
        end
        m_q.push_back('{rw: mrw, mw: mmw});
        @(posedge clk);
        #1;
        me = m_q.pop_front();
        chk({tag, ".reg_write_m"}, 32'(reg_write_m), 32'(me.rw));
        chk({tag, ".mem_write_m"}, 32'(mem_write_m), 32'(me.mw));
        chk({tag, ".exec_count"}, 32'(exec_count), 32'(mexec));
        chk({tag, ".squash_count"}, 32'(squash_count), 32'(msquash));
        @(negedge clk);
    endtask

    // Idle read of a bank through flags_e
    task automatic peek(input string tag, input logic [CTX_W-1:0] c, input logic [3:0] exp);
        valid_e = 1'b0; ctx_e = c; en = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        #1;
        chk(tag, 32'(flags_e), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        model_reset();
        reset = 1'b0; en = 1'b1; flush = 1'b0; valid_e = 1'b0; ctx_e = '0;
        cond_e = 4'b1110; alu_flags_e = 4'b0000; flag_w_e = 2'b00;
        pcs_e = 1'b0; reg_w_e = 1'b0; mem_w_e = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.reg_write_m", 32'(reg_write_m), 32'd0);
        chk("rst.mem_write_m", 32'(mem_write_m), 32'd0);
        chk("rst.exec_count", 32'(exec_count), 32'd0);
        chk("rst.squash_count", 32'(squash_count), 32'd0);
        chk("rst.flags_e", 32'(flags_e), 32'd0);
        reset = 1'b1;

        // SUBS then BEQ in ctx 0
        step("subs", 1, 0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1, 0, 0);
        step("beq",  1, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 1, 0, 0);
        chk("beq.exec_total", 32'(exec_count), 32'd2);
        peek("beq.flags0", 0, 4'b0100);

        // Bank isolation
        step("wr_ctx1", 1, 1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 1, 0, 0);
        step("mi_ctx0", 1, 0, 4'b0100, 4'b0000, 2'b00, 0, 1, 0, 1, 0, 0);
        chk("mi.reg_write_m", 32'(reg_write_m), 32'd0);
        chk("mi.squash_total", 32'(squash_count), 32'd1);
        peek("iso.flags1", 1, 4'b1000);

        // Partial NZ-only write keeps C and V
        step("set0110", 1, 0, 4'b1110, 4'b0110, 2'b11, 0, 0, 0, 1, 0, 0);
        step("nz_only", 1, 0, 4'b1110, 4'b1001, 2'b10, 0, 0, 0, 1, 0, 0);
        peek("partial.flags0", 0, 4'b1010);
        step("gt", 1, 0, 4'b1100, 4'b0000, 2'b00, 0, 1, 0, 1, 0, 0);
        chk("gt.squash_total", 32'(squash_count), 32'd2);

        // Stall then flush
        step("str_live",  1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 1, 0, 0);
        chk("str_live.mem_write_m", 32'(mem_write_m), 32'd1);
        step("str_stall", 1, 0, 4'b1110, 4'b1111, 2'b11, 1, 0, 1, 0, 0, 0);
        chk("stall.mem_write_m", 32'(mem_write_m), 32'd1);
        chk("stall.exec_total", 32'(exec_count), 32'd6);
        step("flush_stall", 1, 0, 4'b1110, 4'b1111, 2'b11, 1, 0, 1, 0, 1, 0);
        chk("flush.mem_write_m", 32'(mem_write_m), 32'd0);
        peek("flush.flags0", 0, 4'b1010);

        // Saturation then clear
        for (int i = 0; i < 17; i++) begin
            step("sat", 1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0);
        end
        chk("sat.exec_total", 32'(exec_count), 32'd15);
        step("clr", 1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 1);
        chk("clr.exec_total", 32'(exec_count), 32'd0);

        // Async reset between edges
        step("rw_live", 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 1, 0, 0);
        chk("rw_live.reg_write_m", 32'(reg_write_m), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.reg_write_m", 32'(reg_write_m), 32'd0);
        chk("arst.flags_e", 32'(flags_e), 32'd0);
        chk("arst.squash_count", 32'(squash_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step("nv", 1, 0, 4'b1111, 4'b0000, 2'b11, 1, 1, 1, 1, 0, 0);
        chk("nv.squash_total", 32'(squash_count), 32'd1);
        chk("nv.exec_total", 32'(exec_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_condlogic_pipe
